booth_mac_sequencer: RTL and testbench
======================================

Name: booth_mac_sequencer

Overview:
- Front-end sequencer and accumulator for the sequential Booth multiplier; sits directly upstream and downstream of it.
- Accepts a stream of signed operand pairs over valid/ready and launches one multiply per pair.
- Sign-extends and accumulates each product, then emits one dot-product result per group, where a group is terminated by in_last.

Parameters:
NB, 4, operand width; must match the multiplier's nb
GUARD, 4, accumulator guard bits; ACC_W = 2*NB+GUARD
CNT_W, 8, product-counter width
TMO, 64, maximum WAIT cycles before timeout abort (>=2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  operand pair valid
in_ready  out  1  sequencer can accept a pair
in_a  in  NB  multiplicand, two's complement
in_b  in  NB  multiplier, two's complement
in_last  in  1  pair is last of group
booth_start  out  1  one-cycle launch pulse to multiplier
booth_m  out  NB  multiplicand to multiplier
booth_q  out  NB  multiplier operand to multiplier
booth_valid  in  1  multiplier result valid
booth_o  in  2*NB  multiplier product, signed
out_valid  out  1  group result valid
out_ready  in  1  consumer accepts result
out_acc  out  ACC_W  accumulated sum, signed
out_count  out  CNT_W  products accumulated in group
out_ovf  out  1  sticky signed overflow within group
out_err  out  1  group aborted by timeout

Behaviour:
- Reset (synchronous, priority over everything): state IDLE; in_ready=1; booth_start=0; booth_m=booth_q=0; out_valid=0; acc=0; count=0; out_ovf=0; out_err=0.
- Reset mid-operation: any in-flight multiply is discarded. booth_valid is ignored until the next LAUNCH.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, register a, b, last; go to LAUNCH. No other state asserts in_ready.
  - LAUNCH (1 cycle): booth_start=1; clear seen_low; clear timer; go to WAIT.
  - WAIT: booth_start=0.
    - If booth_valid==0, set seen_low.
    - If booth_valid==1 && seen_low, capture booth_o and go to ACCUM. This rejects a stale valid left over from the previous operation.
    - Timer increments each WAIT cycle. At timer==TMO-1 without capture: set out_err and go to OUTPUT. acc/count keep their prior values.
  - ACCUM (1 cycle):
    - acc <= acc + sext(product, ACC_W).
    - Signed overflow (operand signs equal, result sign differs) sets out_ovf, sticky; acc wraps modulo 2^ACC_W.
    - count increments, saturating at 2^CNT_W-1.
    - last ? OUTPUT : IDLE.
  - OUTPUT: out_valid=1. out_acc, out_count, out_ovf, out_err are held stable until out_valid&out_ready. On that handshake: clear acc, count, ovf, err; go to IDLE.
- booth_m/booth_q are driven from the registered operands and held constant from LAUNCH until leaving WAIT.
- Minimum per-pair latency: accept -> LAUNCH -> WAIT (>=2 cycles: low then high) -> ACCUM, i.e. 4 cycles from accept to the next in_ready.
- Minimum group latency adds 1 cycle in OUTPUT.
- in_last on the first pair of a group is legal and yields count=1.

Test Plan:
1. NB=4, GUARD=4: pairs (3,5), (-2,7), (-8,-8, last); bench multiplier model with 3-cycle latency -> out_acc=65, out_count=3, out_ovf=0, out_err=0; exactly 3 single-cycle booth_start pulses.
2. GUARD=0 (ACC_W=8): pairs (-8,-8), (-8,-8, last) -> out_acc=-128 (0x80), out_ovf=1, out_count=2; next group (1,1, last) -> out_acc=1, out_ovf=0.
3. Model holds booth_valid high from previous result through 2 cycles after start, then low 1 cycle, then high with product 6 for pair (2,3, last) -> stale value not captured; out_acc=6.
4. TMO=16, pair (1,1) accepted, model never asserts valid -> after 16 WAIT cycles out_valid=1, out_err=1, out_count=0, out_acc=0; the next group after handshake completes normally with out_err=0.
5. Backpressure: out_ready=0 for 5 cycles with out_valid=1 -> in_ready=0 and all out_* stable throughout; out_ready=1 -> one handshake, in_ready=1 the next cycle.
6. rst asserted for 1 cycle while in WAIT of second pair -> next cycle: IDLE, in_ready=1, acc=0; late booth_valid ignored; new group (4,4, last) -> out_acc=16, out_count=1.

Source files
------------

// File: rtl/booth_mac_sequencer.sv
// Operand sequencer and dot-product accumulator wrapped around the
// sequential Booth multiplier.
module booth_mac_sequencer #(
  parameter int NB    = 4,
  parameter int GUARD = 4,
  parameter int CNT_W = 8,
  parameter int TMO   = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NB-1:0]         in_a,
  input  logic [NB-1:0]         in_b,
  input  logic                  in_last,
  output logic                  booth_start,
  output logic [NB-1:0]         booth_m,
  output logic [NB-1:0]         booth_q,
  input  logic                  booth_valid,
  input  logic [2*NB-1:0]       booth_o,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*NB+GUARD-1:0] out_acc,
  output logic [CNT_W-1:0]      out_count,
  output logic                  out_ovf,
  output logic                  out_err
);

  localparam int ACC_W = 2*NB+GUARD;
  localparam int TW    = $clog2(TMO);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_ACCUM,
    S_OUTPUT
  } state_t;

  state_t          state;
  logic            last;
  logic            seen_low;
  logic [TW-1:0]   timer;
  logic [2*NB-1:0] prod;
  logic [ACC_W-1:0] ext;
  logic [ACC_W-1:0] sum;
  logic            add_ovf;

  always_comb begin
    ext     = ACC_W'($signed(prod));
    sum     = out_acc + ext;
    add_ovf = (out_acc[ACC_W-1] == ext[ACC_W-1]) &&
              (sum[ACC_W-1] != out_acc[ACC_W-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      in_ready    <= 1'b1;
      booth_start <= 1'b0;
      booth_m     <= '0;
      booth_q     <= '0;
      last        <= 1'b0;
      seen_low    <= 1'b0;
      timer       <= '0;
      prod        <= '0;
      out_valid   <= 1'b0;
      out_acc     <= '0;
      out_count   <= '0;
      out_ovf     <= 1'b0;
      out_err     <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            booth_m     <= in_a;
            booth_q     <= in_b;
            last        <= in_last;
            in_ready    <= 1'b0;
            booth_start <= 1'b1;
            state       <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          booth_start <= 1'b0;
          seen_low    <= 1'b0;
          timer       <= '0;
          state       <= S_WAIT;
        end
        S_WAIT: begin
          // a valid is only trusted once it has been seen low first
          if (!booth_valid)
            seen_low <= 1'b1;
          if (booth_valid && seen_low) begin
            prod  <= booth_o;
            state <= S_ACCUM;
          end else if (timer == TW'(TMO-1)) begin
            out_err   <= 1'b1;
            out_valid <= 1'b1;
            state     <= S_OUTPUT;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_ACCUM: begin
          out_acc <= sum;
          if (add_ovf)
            out_ovf <= 1'b1;
          if (out_count != '1)
            out_count <= out_count + 1'b1;
          if (last) begin
            out_valid <= 1'b1;
            state     <= S_OUTPUT;
          end else begin
            in_ready <= 1'b1;
            state    <= S_IDLE;
          end
        end
        S_OUTPUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_acc   <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
            out_err   <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mac_sequencer.sv
// Bench for booth_mac_sequencer: two instances (GUARD=4 and GUARD=0)
// share one stimulus stream and a behavioural multiplier model.
module tb_booth_mac_sequencer;

  localparam int NB    = 4;
  localparam int CNT_W = 8;
  localparam int TMO   = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            in_valid = 1'b0;
  logic            in_last = 1'b0;
  logic [NB-1:0]   in_a = '0;
  logic [NB-1:0]   in_b = '0;
  logic            booth_valid = 1'b0;
  logic [2*NB-1:0] booth_o = '0;
  logic            out_ready = 1'b0;

  logic             in_ready, booth_start, out_valid, out_ovf, out_err;
  logic [NB-1:0]    booth_m, booth_q;
  logic [11:0]      out_acc;
  logic [CNT_W-1:0] out_count;

  logic             g_in_ready, g_booth_start, g_out_valid;
  logic             g_out_ovf, g_out_err;
  logic [NB-1:0]    g_booth_m, g_booth_q;
  logic [7:0]       g_out_acc;
  logic [CNT_W-1:0] g_out_count;

  booth_mac_sequencer #(.NB(NB), .GUARD(4), .CNT_W(CNT_W), .TMO(TMO)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .booth_start(booth_start), .booth_m(booth_m), .booth_q(booth_q),
    .booth_valid(booth_valid), .booth_o(booth_o),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_count(out_count),
    .out_ovf(out_ovf), .out_err(out_err)
  );

  booth_mac_sequencer #(.NB(NB), .GUARD(0), .CNT_W(CNT_W), .TMO(TMO)) u_g0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(g_in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .booth_start(g_booth_start), .booth_m(g_booth_m), .booth_q(g_booth_q),
    .booth_valid(booth_valid), .booth_o(booth_o),
    .out_valid(g_out_valid), .out_ready(out_ready),
    .out_acc(g_out_acc), .out_count(g_out_count),
    .out_ovf(g_out_ovf), .out_err(g_out_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Multiplier model: 0 = normal, 1 = never answers, 2 = stale valid.
  int              m_mode = 0;
  int              m_lat = 3;
  int              m_cnt = 0;
  bit              m_pend = 0;
  logic [2*NB-1:0] m_prod = '0;

  initial forever begin
    int sa, sb, p;
    @(negedge clk);
    if (booth_start) begin
      sa = $signed(booth_m);
      sb = $signed(booth_q);
      p  = sa * sb;
      m_prod = p[2*NB-1:0];
      m_cnt  = 0;
      m_pend = (m_mode != 1);
      if (m_mode == 2) begin
        booth_valid = 1'b1;
        booth_o     = 8'h5A;
      end else begin
        booth_valid = 1'b0;
      end
    end else if (m_pend) begin
      m_cnt++;
      if (m_mode == 2) begin
        if (m_cnt == 3) begin
          booth_valid = 1'b0;
        end else if (m_cnt == 4) begin
          booth_valid = 1'b1;
          booth_o     = m_prod;
          m_pend      = 0;
        end
      end else if (m_cnt == m_lat) begin
        booth_valid = 1'b1;
        booth_o     = m_prod;
        m_pend      = 0;
      end
    end
  end

  int n_start = 0;
  int n_dbl   = 0;
  bit prev_st = 0;

  initial forever begin
    @(negedge clk);
    if (booth_start) begin
      n_start++;
      if (prev_st) n_dbl++;
    end
    prev_st = booth_start;
  end

  // Reference accumulator: exact integer sum, wrapped to w bits.
  function automatic void ref_add(inout longint s, inout bit o,
                                  input longint p, input int w);
    longint t, lim, m;
    lim = longint'(1) << (w-1);
    m   = lim * 2;
    t   = s + p;
    if (t >= lim || t < -lim) o = 1;
    t = ((t % m) + m) % m;
    if (t >= lim) t -= m;
    s = t;
  endfunction

  task automatic send(input int a, input int b, input bit last);
    int t;
    t = 0;
    while (!in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("in_ready_wait", longint'(t < 300), 1);
    in_a     = a[NB-1:0];
    in_b     = b[NB-1:0];
    in_last  = last;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic get_res(input int e_acc, input int e_acc0, input int e_cnt,
                         input int e_ovf, input int e_ovf0, input int e_err,
                         input int hold, output int waited);
    waited = 0;
    while (!out_valid && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    chk("out_valid_wait", out_valid, 1);
    for (int i = 0; i <= hold; i++) begin
      if (i > 0) @(negedge clk);
      chk("out_valid_held", out_valid, 1);
      chk("g0_out_valid", g_out_valid, 1);
      chk("out_acc", $signed(out_acc), e_acc);
      chk("g0_out_acc", $signed(g_out_acc), e_acc0);
      chk("out_count", out_count, e_cnt);
      chk("g0_out_count", g_out_count, e_cnt);
      chk("out_ovf", out_ovf, e_ovf);
      chk("g0_out_ovf", g_out_ovf, e_ovf0);
      chk("out_err", out_err, e_err);
      chk("g0_out_err", g_out_err, e_err);
      chk("in_ready_busy", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_drop", out_valid, 0);
    chk("in_ready_after", in_ready, 1);
    chk("g0_in_ready_after", g_in_ready, 1);
  endtask

  typedef struct {
    int a; int b; int last; int lat;
    int e_acc; int e_acc0; int e_cnt; int e_ovf; int e_ovf0;
  } vec_t;

  vec_t   tv[9];
  int     s0, np, w, ng;
  longint r_s4, r_s0;
  bit     r_o4, r_o0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tv[0] = '{3, 5, 0, 3, 0, 0, 0, 0, 0};
    tv[1] = '{-2, 7, 0, 3, 0, 0, 0, 0, 0};
    tv[2] = '{-8, -8, 1, 3, 65, 65, 3, 0, 0};
    tv[3] = '{-8, -8, 0, 2, 0, 0, 0, 0, 0};
    tv[4] = '{-8, -8, 1, 2, 128, -128, 2, 0, 1};
    tv[5] = '{1, 1, 1, 4, 1, 1, 1, 0, 0};
    tv[6] = '{7, -8, 1, 2, -56, -56, 1, 0, 0};
    tv[7] = '{-1, -1, 0, 5, 0, 0, 0, 0, 0};
    tv[8] = '{7, 7, 1, 2, 50, 50, 2, 0, 0};

    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_booth_start", booth_start, 0);
    chk("rst_booth_m", booth_m, 0);
    chk("rst_booth_q", booth_q, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_acc", out_acc, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_out_ovf", out_ovf, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_g0_in_ready", g_in_ready, 1);
    chk("rst_g0_start", g_booth_start, 0);
    chk("rst_g0_m", g_booth_m, 0);
    chk("rst_g0_q", g_booth_q, 0);
    rst = 1'b0;
    @(negedge clk);

    np = 0;
    s0 = 0;
    foreach (tv[i]) begin
      m_mode = 0;
      m_lat  = tv[i].lat;
      if (np == 0) s0 = n_start;
      send(tv[i].a, tv[i].b, tv[i].last != 0);
      np++;
      if (tv[i].last != 0) begin
        get_res(tv[i].e_acc, tv[i].e_acc0, tv[i].e_cnt,
                tv[i].e_ovf, tv[i].e_ovf0, 0, 0, w);
        chk("start_pulses", n_start - s0, np);
        chk("start_single_cycle", n_dbl, 0);
        np = 0;
      end
    end

    for (int g = 0; g < 6; g++) begin
      ng   = int'($urandom_range(4, 1));
      r_s4 = 0; r_s0 = 0; r_o4 = 0; r_o0 = 0;
      for (int p = 0; p < ng; p++) begin
        int a, b;
        a = int'($urandom_range(15)) - 8;
        b = int'($urandom_range(15)) - 8;
        m_lat = int'($urandom_range(6, 2));
        ref_add(r_s4, r_o4, a * b, 12);
        ref_add(r_s0, r_o0, a * b, 8);
        send(a, b, p == ng - 1);
      end
      get_res(int'(r_s4), int'(r_s0), ng, r_o4, r_o0, 0, 0, w);
    end

    m_mode = 2;
    send(2, 3, 1);
    get_res(6, 6, 1, 0, 0, 0, 0, w);

    m_mode = 1;
    send(1, 1, 0);
    get_res(0, 0, 0, 0, 0, 1, 0, w);
    chk("timeout_latency", w, TMO + 1);
    m_mode = 0;
    m_lat  = 3;
    send(2, 2, 1);
    get_res(4, 4, 1, 0, 0, 0, 0, w);

    m_lat = 2;
    send(1, 2, 1);
    get_res(2, 2, 1, 0, 0, 0, 5, w);

    m_lat = 6;
    send(1, 1, 0);
    send(2, 2, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_acc", out_acc, 0);
    chk("midrst_count", out_count, 0);
    repeat (8) @(negedge clk);
    chk("late_valid_in_ready", in_ready, 1);
    chk("late_valid_out_valid", out_valid, 0);
    m_lat = 3;
    send(4, 4, 1);
    get_res(16, 16, 1, 0, 0, 0, 0, w);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
